// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmit serialiser.
//
// Frame on TX_OUT: START(0), 8 data bits LSB first, optional PARITY, STOP(1).
// Each bit lasts N clocks, where N is the prescale value latched at accept time
// (a prescale of 0 is treated as 1). The line idles high.
//
// Build option: define UART_TX_HOLD_EN to add a one-entry hold register. With it,
// a request that arrives while a frame is in flight is parked and then sent
// directly after the current STOP bit, with no idle gap. Without it, requests that
// arrive while busy are dropped and hold_full is tied low.
module uart_tx_frame #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     P_data,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  hold_full
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Frame being transmitted. These are latched at accept time, so later changes
  // on the inputs cannot disturb a frame in flight.
  logic [DATA_W-1:0]     r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [PRESCALE_W-1:0] r_bit_len;

  // Timing within the frame.
  logic [PRESCALE_W-1:0] r_baud_cnt;
  logic [IDX_W-1:0]      r_bit_idx;

  logic                  w_bit_done;
  logic                  w_last_data_bit;
  logic                  w_parity;
  logic [PRESCALE_W-1:0] w_in_bit_len;
  logic                  w_load_new;

  // Hold-path view. These are constants when the hold register is not built.
  logic                  w_hold_full;
  logic                  w_hold_drain;
  logic [DATA_W-1:0]     w_hold_data;
  logic                  w_hold_par_en;
  logic                  w_hold_par_typ;
  logic [PRESCALE_W-1:0] w_hold_bit_len;

  // A prescale of zero would leave the baud counter without a terminal count.
  assign w_in_bit_len = (prescale == '0) ? PRESCALE_W'(1) : prescale;

  // The current bit has used its last clock.
  assign w_bit_done = (r_state != S_IDLE) && (r_baud_cnt == (r_bit_len - PRESCALE_W'(1)));

  assign w_last_data_bit = (r_bit_idx == IDX_W'(DATA_W - 1));

  // Even parity makes the total count of ones even, so the parity bit is the XOR
  // of the data. Odd parity is its inverse.
  assign w_parity = r_par_typ ? ~^r_data : ^r_data;

  // A direct accept happens only from IDLE. If a parked request is waiting, it is
  // sent first.
  assign w_load_new = (r_state == S_IDLE) && data_valid && !w_hold_full;

`ifdef UART_TX_HOLD_EN
  logic                  r_hold_full;
  logic [DATA_W-1:0]     r_hold_data;
  logic                  r_hold_par_en;
  logic                  r_hold_par_typ;
  logic [PRESCALE_W-1:0] r_hold_bit_len;
  logic                  w_hold_cap;

  // The parked request is released at the end of the STOP bit. It is also
  // released from IDLE, which covers a capture made on the final STOP edge.
  assign w_hold_drain = r_hold_full &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));

  // Capture is allowed while busy with an empty entry. It is also allowed on the
  // edge that drains the entry: the drained request leaves and the new one takes
  // the freed slot in the same cycle.
  assign w_hold_cap = data_valid &&
                      (((r_state != S_IDLE) && !r_hold_full) || w_hold_drain);

  // Hold register: capture new requests, and clear the entry when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full    <= 1'b0;
      r_hold_data    <= '0;
      r_hold_par_en  <= 1'b0;
      r_hold_par_typ <= 1'b0;
      r_hold_bit_len <= '0;
    end else begin
      if (w_hold_cap) begin
        r_hold_full    <= 1'b1;
        r_hold_data    <= P_data;
        r_hold_par_en  <= PAR_EN;
        r_hold_par_typ <= PAR_TYP;
        r_hold_bit_len <= w_in_bit_len;
      end else if (w_hold_drain) begin
        r_hold_full    <= 1'b0;
      end
    end
  end

  assign w_hold_full    = r_hold_full;
  assign w_hold_data    = r_hold_data;
  assign w_hold_par_en  = r_hold_par_en;
  assign w_hold_par_typ = r_hold_par_typ;
  assign w_hold_bit_len = r_hold_bit_len;
  assign hold_full      = r_hold_full;
`else
  assign w_hold_full    = 1'b0;
  assign w_hold_drain   = 1'b0;
  assign w_hold_data    = '0;
  assign w_hold_par_en  = 1'b0;
  assign w_hold_par_typ = 1'b0;
  assign w_hold_bit_len = '0;
  assign hold_full      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so that every flop samples the
    // values from before the edge, whatever order the blocks are evaluated in.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the frame configuration, either from the inputs or from the hold entry.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers are reset as well. This keeps the TX_OUT decode
    // free of X after reset, and costs nothing at this size.
    if (rst) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_bit_len <= '0;
    end else if (w_hold_drain) begin
      r_data    <= w_hold_data;
      r_par_en  <= w_hold_par_en;
      r_par_typ <= w_hold_par_typ;
      r_bit_len <= w_hold_bit_len;
    end else if (w_load_new) begin
      r_data    <= P_data;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
      r_bit_len <= w_in_bit_len;
    end
  end

  // Baud counter: counts 0..N-1 within each bit and sits at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit_done) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + PRESCALE_W'(1);
    end
  end

  // Data bit index: advances at the end of each data bit and is 0 outside DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
    end else if (r_state != S_DATA) begin
      r_bit_idx <= '0;
    end else if (w_bit_done) begin
      r_bit_idx <= r_bit_idx + IDX_W'(1);
    end
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    // NOTE: default first, so that no path through the case leaves the value
    // unassigned (that would infer a latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load_new || w_hold_drain) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_done && w_last_data_bit) begin
          w_next_state = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_next_state = w_hold_drain ? S_START : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode: the line level and busy follow the registered state.
  always_comb begin
    TX_OUT = 1'b1;
    busy   = 1'b1;
    case (r_state)
      S_IDLE:   busy   = 1'b0;
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = r_data[r_bit_idx];
      S_PARITY: TX_OUT = w_parity;
      S_STOP:   TX_OUT = 1'b1;
      default: begin
        TX_OUT = 1'b1;
        busy   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame -- scoreboard bench for uart_tx_frame.
// Each directed request pushes its hand-computed line waveform into a queue. A
// monitor detects frame starts on TX_OUT and checks each frame clock by clock.
// The bench follows the build macro UART_TX_HOLD_EN in the same way as the RTL.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] P_data;
  logic       data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] prescale;
  logic       TX_OUT;
  logic       busy;
  logic       hold_full;

  // Expected frame. bits[nbits-1] is the first line level sent (the START bit).
  // trunc != 0 means a reset cuts the frame after that many clocks.
  // b2b = 1 means this frame starts straight after the previous STOP bit.
  typedef struct {
    int          id;
    logic [10:0] bits;
    int          nbits;
    int          n;
    int          trunc;
    bit          b2b;
  } exp_frame_t;

  exp_frame_t sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_active = 1'b0;

  uart_tx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .P_data     (P_data),
    .data_valid (data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .hold_full  (hold_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [10:0] bits, input int nbits,
                      input int n, input int trunc, input bit b2b);
    exp_frame_t e;
    e.id    = id;
    e.bits  = bits;
    e.nbits = nbits;
    e.n     = n;
    e.trunc = trunc;
    e.b2b   = b2b;
    sb_q.push_back(e);
  endtask

  // One-clock request strobe. The task returns 1 time unit after the accept edge.
  // After that edge the inputs are scrambled, to show the frame was latched.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    @(posedge clk);
    #1;
    P_data = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    P_data = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; prescale = 5'd3;
  endtask

  // Call this at a posedge. The strobe is seen on the following edge.
  task automatic strobe(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    #1;
    P_data = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Wait until the DUT is idle and every expected frame has been checked.
  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0 || mon_active) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check({name, "_drain_timeout"}, {31'd0, cyc < 3000}, 32'd1);
    if (cyc >= 3000) sb_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // Monitor: samples on the falling edge and checks one comparison per bit.
  initial begin : monitor
    exp_frame_t e;
    bit         pending;
    bit         bad;
    bit         nb2b;
    logic [1:0] act;
    logic       expb;
    int         total;
    pending = 1'b0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        if (rst !== 1'b0 || TX_OUT !== 1'b0) continue;
      end
      pending = 1'b0;
      if (sb_q.size() == 0) begin
        check("unexpected_frame_start", {31'd0, TX_OUT}, 32'd1);
        continue;
      end
      e = sb_q.pop_front();
      mon_active = 1'b1;
      total = (e.trunc != 0) ? e.trunc : e.nbits * e.n;
      bad = 1'b0;
      act = 2'b00;
      for (int c = 0; c < total; c++) begin
        if (c != 0) @(negedge clk);
        expb = e.bits[e.nbits - 1 - c / e.n];
        if (!bad) act = {busy, TX_OUT};
        if ({busy, TX_OUT} !== {1'b1, expb}) bad = 1'b1;
        if ((c % e.n == e.n - 1) || (c == total - 1)) begin
          check($sformatf("frame%0d_bit%0d", e.id, c / e.n), {30'd0, act}, {30'd0, 1'b1, expb});
          bad = 1'b0;
        end
      end
      @(negedge clk);
      nb2b = (e.trunc == 0) && (sb_q.size() != 0) && sb_q[0].b2b;
      check($sformatf("frame%0d_after", e.id), {30'd0, busy, TX_OUT}, nb2b ? 32'd2 : 32'd1);
      if (nb2b) pending = 1'b1;
      else      mon_active = 1'b0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit moved;
    rst = 1'b1; data_valid = 1'b0; P_data = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd0;

    // T1: reset state, then a quiet idle line.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx_out", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hold_full", {31'd0, hold_full}, 32'd0);
    rst = 1'b0;
    moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) moved = 1'b1;
    end
    check("idle_quiet", {31'd0, moved}, 32'd0);

    // T2: 0x85, even parity, 16 clocks per bit.
    push(2, 11'b01010000111, 11, 16, 0, 1'b0);
    send(8'h85, 1'b1, 1'b0, 5'd16);
    wait_idle("t2");

    // T3: 0xFF, no parity, prescale 0 treated as 1.
    push(3, 11'b00111111111, 10, 1, 0, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 5'd0);
    wait_idle("t3");

    // T4: 0x00, odd parity, so the parity bit is 1.
    push(4, 11'b00000000011, 11, 4, 0, 1'b0);
    send(8'h00, 1'b1, 1'b1, 5'd4);
    wait_idle("t4");

    // T5: reset at clock 50 of a T2 frame. A request made at clock 20 must be
    // discarded by the reset too.
    push(5, 11'b01010000111, 11, 16, 50, 1'b0);
    send(8'h85, 1'b1, 1'b0, 5'd16);
    repeat (19) @(posedge clk);
    strobe(8'h3C, 1'b0, 1'b0, 5'd2);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_hold_cleared", {31'd0, hold_full}, 32'd0);
    @(negedge clk);
    check("t5_no_frame_after_reset", {31'd0, busy}, 32'd0);
    push(6, 11'b01010000111, 11, 16, 0, 1'b0);
    send(8'h85, 1'b1, 1'b0, 5'd16);
    wait_idle("t5_fresh");

`ifndef UART_TX_HOLD_EN
    // Held-high strobe: one frame per return to IDLE, with a one-clock gap.
    push(7, 11'b00101001011, 10, 1, 0, 1'b0);
    push(8, 11'b00101001011, 10, 1, 0, 1'b0);
    @(posedge clk);
    #1;
    P_data = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd1; data_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 data_valid = 1'b0;
    wait_idle("held_strobe");
`endif

    // T6: strobe 0x3C at clock 20 of a T2 frame.
    push(9, 11'b01010000111, 11, 16, 0, 1'b0);
    send(8'h85, 1'b1, 1'b0, 5'd16);
    repeat (19) @(posedge clk);
`ifdef UART_TX_HOLD_EN
    push(10, 11'b00001111001, 10, 2, 0, 1'b1);
`endif
    strobe(8'h3C, 1'b0, 1'b0, 5'd2);
    @(negedge clk);
`ifdef UART_TX_HOLD_EN
    check("t6_hold_full", {31'd0, hold_full}, 32'd1);
    // A second request while the entry is occupied is dropped.
    repeat (10) @(posedge clk);
    strobe(8'h99, 1'b1, 1'b1, 5'd5);
    @(negedge clk);
    check("t6_hold_still_full", {31'd0, hold_full}, 32'd1);
`else
    check("t6_hold_full", {31'd0, hold_full}, 32'd0);
`endif
    wait_idle("t6");
    check("t6_final_hold_full", {31'd0, hold_full}, 32'd0);

`ifdef UART_TX_HOLD_EN
    // T7: a capture on the same edge as the drain refills the freed entry.
    push(11, 11'b00111111111, 10, 1, 0, 1'b0);
    push(12, 11'b00111100001, 10, 1, 0, 1'b1);
    push(13, 11'b00000111101, 11, 2, 0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 5'd1);
    @(posedge clk);
    strobe(8'h0F, 1'b0, 1'b0, 5'd1);
    repeat (7) @(posedge clk);
    strobe(8'hF0, 1'b1, 1'b0, 5'd2);
    @(negedge clk);
    check("t7_refill_hold_full", {31'd0, hold_full}, 32'd1);
    wait_idle("t7");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
